// File: rtl/hdmi_timing_gen.sv
// Video raster timing generator: pixel/line counters with registered,
// zero-skew decodes for data enable, syncs, strobes and a lead-ahead fetch.
module hdmi_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FP       = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 20,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned FETCH_LEAD = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        enable,
  output logic [11:0] hcount,
  output logic [10:0] vcount,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        fetch
);

  localparam int unsigned HW      = 12;
  localparam int unsigned VW      = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW:0]   LEAD_W    = (HW+1)'(FETCH_LEAD);
  localparam logic [HW:0]   H_TOTAL_W = (HW+1)'(H_TOTAL);

  logic [HW-1:0] nh;
  logic [VW-1:0] nv;
  logic [HW:0]   la_sum;
  logic [HW-1:0] la_h;
  logic [VW-1:0] la_v;

  // Next raster position and the position FETCH_LEAD pixels beyond it.
  always_comb begin
    nh = hcount + HW'(1);
    nv = vcount;
    if (hcount == H_LAST) begin
      nh = '0;
      nv = (vcount == V_LAST) ? '0 : vcount + VW'(1);
    end
    la_sum = {1'b0, nh} + LEAD_W;
    la_h   = la_sum[HW-1:0];
    la_v   = nv;
    if (la_sum >= H_TOTAL_W) begin
      la_h = HW'(la_sum - H_TOTAL_W);
      la_v = (nv == V_LAST) ? '0 : nv + VW'(1);
    end
  end

  // Decodes are computed from the next position so they land with the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch       <= 1'b0;
    end else if (!pll_locked) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch       <= 1'b0;
    end else if (enable) begin
      hcount      <= nh;
      vcount      <= nv;
      de          <= (nh < H_ACT) && (nv < V_ACT);
      hsync       <= ((nh >= HS_START) && (nh < HS_END)) ? HS_POL : ~HS_POL;
      vsync       <= ((nv >= VS_START) && (nv < VS_END)) ? VS_POL : ~VS_POL;
      line_start  <= (nh == '0);
      frame_start <= (nh == '0) && (nv == '0);
      fetch       <= (la_h < H_ACT) && (la_v < V_ACT);
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a reduced raster: directed vectors, a linear
// pixel-index reference model under random enable / lock, and reset corners.
module tb_hdmi_timing_gen;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 4;
  localparam int VA = 5, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int LEAD = 2;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;

  typedef struct packed {
    logic [11:0] h;
    logic [10:0] v;
    logic de, hs, vs, ls, fs, fe;
  } out_t;

  typedef struct {
    int adv;
    int h, v, de, hs, vs, ls, fs, fe;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n, pll_locked, enable;
  logic [11:0] hcount;
  logic [10:0] vcount;
  logic de, hsync, vsync, line_start, frame_start, fetch;
  out_t dut_o;

  int n_checks = 0;
  int n_pass = 0;
  int m_idx;
  bit m_rst;

  always #5 clk = ~clk;

  assign dut_o = {hcount, vcount, de, hsync, vsync, line_start, frame_start, fetch};

  hdmi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .FETCH_LEAD(LEAD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .enable(enable),
    .hcount(hcount), .vcount(vcount), .de(de), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .fetch(fetch)
  );

  function automatic out_t mk(int h, int v, int de_i, int hs_i, int vs_i, int ls_i, int fs_i, int fe_i);
    out_t o;
    o.h  = 12'(h);
    o.v  = 11'(v);
    o.de = 1'(de_i);
    o.hs = 1'(hs_i);
    o.vs = 1'(vs_i);
    o.ls = 1'(ls_i);
    o.fs = 1'(fs_i);
    o.fe = 1'(fe_i);
    return o;
  endfunction

  function automatic int active_at(int idx);
    return ((idx % HT) < HA && (idx / HT) < VA) ? 1 : 0;
  endfunction

  // Reference outputs from the linear pixel index within the frame.
  function automatic out_t model_out();
    int h, v;
    if (m_rst) return mk(HT-1, VT-1, 0, !HSP, !VSP, 0, 0, 0);
    h = m_idx % HT;
    v = m_idx / HT;
    return mk(h, v, active_at(m_idx),
              (h >= HA+HFP && h < HA+HFP+HSW) ? int'(HSP) : int'(!HSP),
              (v >= VA+VFP && v < VA+VFP+VSW) ? int'(VSP) : int'(!VSP),
              (h == 0) ? 1 : 0, (m_idx == 0) ? 1 : 0,
              active_at((m_idx + LEAD) % FT));
  endfunction

  function automatic void model_reset();
    m_rst = 1'b1;
    m_idx = FT - 1;
  endfunction

  task automatic step(input bit en, input bit lk);
    enable = en;
    pll_locked = lk;
    @(posedge clk);
    if (!lk) model_reset();
    else if (en) begin
      m_idx = (m_idx + 1) % FT;
      m_rst = 1'b0;
    end
    #1;
  endtask

  task automatic check(input string name, input out_t exp);
    n_checks++;
    if (dut_o === exp) n_pass++;
    else $display("FAIL %s: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fe=%b, expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fe=%b",
                  name, dut_o.h, dut_o.v, dut_o.de, dut_o.hs, dut_o.vs, dut_o.ls, dut_o.fs, dut_o.fe,
                  exp.h, exp.v, exp.de, exp.hs, exp.vs, exp.ls, exp.fs, exp.fe);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  initial begin
    vec_t tbl[17];
    out_t rst_o;
    int steps, n_de, n_fe, n_hs, n_hsp, n_vs, n_fs, n_ls;
    bit en, prev_hs;

    rst_o = mk(HT-1, VT-1, 0, !HSP, !VSP, 0, 0, 0);
    tbl[0]  = '{1,  0, 0, 1, 0, 1, 1, 1, 1};
    tbl[1]  = '{0,  0, 0, 1, 0, 1, 1, 1, 1};
    tbl[2]  = '{5,  5, 0, 1, 0, 1, 0, 0, 1};
    tbl[3]  = '{1,  6, 0, 1, 0, 1, 0, 0, 0};
    tbl[4]  = '{2,  8, 0, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{2, 10, 0, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{3, 13, 0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{2, 15, 0, 0, 0, 1, 0, 0, 1};
    tbl[8]  = '{2,  0, 1, 1, 0, 1, 1, 0, 1};
    tbl[9]  = '{68, 0, 5, 0, 0, 1, 1, 0, 0};
    tbl[10] = '{17, 0, 6, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{34, 0, 8, 0, 0, 1, 1, 0, 0};
    tbl[12] = '{32, 15, 9, 0, 0, 1, 0, 0, 1};
    tbl[13] = '{1, 16, 9, 0, 0, 1, 0, 0, 1};
    tbl[14] = '{1,  0, 0, 1, 0, 1, 1, 1, 1};
    tbl[15] = '{75, 7, 4, 1, 0, 1, 0, 0, 0};
    tbl[16] = '{1,  8, 4, 0, 0, 1, 0, 0, 0};

    reset_n = 1'b0;
    enable = 1'b1;
    pll_locked = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", rst_o);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed raster positions, cumulative from reset release.
    foreach (tbl[i]) begin
      if (tbl[i].adv == 0) step(1'b0, 1'b1);
      else repeat (tbl[i].adv) step(1'b1, 1'b1);
      check($sformatf("vec%0d", i),
            mk(tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs, tbl[i].fe));
    end

    // Align to the last pixel of a frame, then count three frames of enabled edges.
    steps = 0;
    while (m_idx != FT - 1 && steps < 2 * FT) begin
      step(1'b1, 1'b1);
      steps++;
    end
    check_int("align_frame", m_idx, FT - 1);
    n_de = 0; n_fe = 0; n_hs = 0; n_hsp = 0; n_vs = 0; n_fs = 0; n_ls = 0;
    prev_hs = !HSP;
    steps = 0;
    for (int c = 0; c < 16 * FT && steps < 3 * FT; c++) begin
      en = ($urandom_range(0, 3) != 0);
      step(en, 1'b1);
      if (dut_o !== model_out()) check("rand_enable", model_out());
      if (en) begin
        steps++;
        n_de += int'(de);
        n_fe += int'(fetch);
        n_hs += int'(hsync == HSP);
        n_hsp += int'(hsync == HSP && prev_hs != HSP);
        n_vs += int'(vsync == VSP);
        n_fs += int'(frame_start);
        n_ls += int'(line_start);
        prev_hs = hsync;
      end
    end
    check("rand_enable_end", model_out());
    check_int("frames_done", steps, 3 * FT);
    check_int("de_count", n_de, 3 * HA * VA);
    check_int("fetch_count", n_fe, 3 * HA * VA);
    check_int("hsync_cycles", n_hs, 3 * VT * HSW);
    check_int("hsync_pulses", n_hsp, 3 * VT);
    check_int("vsync_cycles", n_vs, 3 * VSW * HT);
    check_int("frame_starts", n_fs, 3);
    check_int("line_starts", n_ls, 3 * VT);

    // Random enable with occasional loss of lock.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) != 0);
      if (dut_o !== model_out()) check("rand_lock", model_out());
    end
    check("rand_lock_end", model_out());

    // Lock drop at (5,3) loads the reset state; next edge restarts the frame.
    steps = 0;
    while ((m_rst || m_idx != 3 * HT + 5) && steps < 2 * FT) begin
      step(1'b1, 1'b1);
      steps++;
    end
    check("at_5_3", mk(5, 3, 1, 0, 1, 0, 0, 1));
    step(1'b1, 1'b0);
    check("lock_drop", rst_o);
    step(1'b1, 1'b1);
    check("lock_resume", mk(0, 0, 1, 0, 1, 1, 1, 1));
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("lock_over_enable", rst_o);
    step(1'b0, 1'b1);
    check("hold_after_drop", rst_o);

    // Asynchronous reset between edges at (4,2).
    step(1'b1, 1'b1);
    repeat (2 * HT + 4) step(1'b1, 1'b1);
    check("at_4_2", mk(4, 2, 1, 0, 1, 0, 0, 1));
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", rst_o);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", rst_o);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b1);
    check("after_async", mk(0, 0, 1, 0, 1, 1, 1, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hdmi_timing_gen.md
HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 110, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 40, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 220, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 720, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 5, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 5, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 20, vertical back porch in lines.
REQ-009 SHALL have parameters HS_POL and VS_POL, default 1 each, giving the active sync level.
REQ-010 SHALL have parameter FETCH_LEAD, default 2, legal range 1..8, pixel-request lead in clocks.
REQ-011 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-012 clk  input  1  pixel clock (PLL clkout0, 74.25 MHz at defaults); the only clock.
REQ-013 reset_n  input  1  asynchronous active-low reset.
REQ-014 pll_locked  input  1  PLL lock, already synchronous to clk.
REQ-015 enable  input  1  advance timing when high.
REQ-016 hcount  output  12  current pixel column.
REQ-017 vcount  output  11  current line.
REQ-018 de  output  1  data enable, high inside the active area.
REQ-019 hsync, vsync  output  1 each  sync outputs at the configured polarity.
REQ-020 line_start, frame_start  output  1 each  single-cycle strobes.
REQ-021 fetch  output  1  pixel-data request, FETCH_LEAD clocks ahead of de.

Function
REQ-022 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1650 at defaults); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (750 at defaults).
REQ-023 Each line SHALL be ordered active, front porch, sync, back porch, starting at hcount 0; each frame SHALL use the same order starting at vcount 0.
REQ-024 On each clk edge with enable=1 and pll_locked=1, hcount SHALL increment; when hcount=H_TOTAL-1, hcount SHALL wrap to 0 and vcount SHALL increment.
REQ-025 When hcount and vcount wrap together (H_TOTAL-1, V_TOTAL-1), both SHALL go to 0 on the same edge.
REQ-026 All outputs SHALL be registered.
REQ-027 de, hsync, vsync, strobes and fetch SHALL be consistent with the hcount/vcount values presented in the same cycle, so there is zero skew between counters and decodes.
REQ-028 de SHALL be 1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-029 hsync SHALL equal HS_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-030 vsync SHALL equal VS_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, and ~VS_POL otherwise.
REQ-031 vsync SHALL change only on cycles where hcount=0.
REQ-032 line_start SHALL be 1 iff hcount=0.
REQ-033 frame_start SHALL be 1 iff hcount=0 and vcount=0.
REQ-034 fetch SHALL be 1 iff the pixel FETCH_LEAD clocks ahead is active: position computed modulo H_TOTAL, with vcount advanced to the next line (and wrapped at V_TOTAL) when the lookahead crosses the line end.
REQ-035 Each fetch high cycle SHALL be matched by exactly one de high cycle FETCH_LEAD enabled clocks later.
REQ-036 The number of fetch high cycles per frame SHALL equal H_ACTIVE*V_ACTIVE.
REQ-037 With enable=0 and pll_locked=1, all outputs SHALL hold their values; a strobe held high is not re-counted as a new event.
REQ-038 pll_locked=0 SHALL dominate enable and, on the next edge, load the reset state of REQ-039, synchronously.

Reset
REQ-039 While reset_n=0 (asynchronous) the outputs SHALL be: hcount=H_TOTAL-1, vcount=V_TOTAL-1, de=0, fetch=0, line_start=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-040 The first enabled, locked edge after reset release SHALL present hcount=0, vcount=0, frame_start=1, line_start=1, de=1.
REQ-041 Reset asserted mid-frame SHALL reach the REQ-039 state immediately, without waiting for a clock edge.

Verification
REQ-042 Release reset with enable=1 and locked=1 -> first cycle h=0, v=0, de=1, frame_start=1; 1650 clocks later, line_start=1 with v=1.
REQ-043 Run one full frame of 1,237,500 clocks -> exactly 921,600 de cycles, 921,600 fetch cycles, 750 hsync pulses of 40 clocks starting at h=1390, and one vsync of 5 lines spanning v=725..729 that starts at h=0.
REQ-044 Check wrap boundaries -> (1649,749) goes to (0,0) with frame_start; (1279,719) goes to (1280,719) with de falling; fetch rises at (1648,749) for FETCH_LEAD=2.
REQ-045 Toggle enable at random for 3 frames -> per-frame counts match REQ-043; outputs stay frozen while enable=0.
REQ-046 Drop pll_locked for 1 cycle at (500,300) -> next cycle shows the reset state; resume -> frame_start on the following edge.
REQ-047 Assert reset_n=0 asynchronously between edges at (800,400) -> outputs reach the REQ-039 values before the next clk edge.
